cliff_game_core: RTL and testbench

- Parametrised single-clock successor to the board-level cliff game.
- Holds a group of GROUP adjacent "people" on a WIDTH-bit LED bar, with two configurable cliffs, a speed-level step timer, a score counter and an IDLE/RUN/LOSE state machine.
- All timing uses tick enables derived from `clk`; there are no generated clocks.
- Sits between the board debouncers (single-cycle pulses in) and the LED and 7-seg drivers (state, speed and score out).

---
 rtl/cliff_game_core.sv | 231 +++++++++++++++++++++++
 tb/tb_cliff_game_core.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cliff_game_core.sv
// Cliff game core: a group of people on an LED bar walks toward two cliffs
// at a selectable speed. It has an IDLE/RUN/LOSE state machine, a step timer,
// a score counter and a blinking lose display. Every register runs on clk.
module cliff_game_core #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned GROUP        = 3,
  parameter int unsigned START_IDX    = 7,
  parameter int unsigned CW           = 3,
  parameter int unsigned LEVELS       = 3,
  parameter int unsigned BASE_PERIOD  = 50000000,
  parameter int unsigned PERIOD_SHIFT = 2,
  parameter int unsigned BLINK_PERIOD = 5000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_p,
  input  logic                      left_p,
  input  logic                      right_p,
  input  logic                      speed_up_p,
  input  logic                      speed_down_p,
  input  logic [CW-1:0]             cliff_l,
  input  logic [CW-1:0]             cliff_r,
  output logic [WIDTH-1:0]          led,
  output logic [1:0]                state,
  output logic [$clog2(LEVELS)-1:0] speed,
  output logic [7:0]                pos,
  output logic [15:0]               score,
  output logic                      step
);

  localparam int unsigned HALF = (GROUP - 1) / 2;
  localparam int unsigned SW   = $clog2(LEVELS);
  localparam int unsigned TW   = $clog2(BASE_PERIOD + 1);
  localparam int unsigned BW   = $clog2(BLINK_PERIOD + 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StLose = 2'd2} state_e;
  typedef enum logic [1:0] {DirNone = 2'd0, DirLeft = 2'd1, DirRight = 2'd2} dir_e;

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [7:0]      pos_q, pos_d;
  logic [SW-1:0]   speed_q, speed_d;
  logic [15:0]     score_q, score_d;
  logic            step_q, step_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;
  logic [7:0]      bl_q, bl_d, br_q, br_d;

  logic [7:0]      bl_live, br_live, bl_act, br_act;
  logic            ovl, can_left, can_right, speed_chg, move;
  logic [TW-1:0]   per_m1;
  logic [WIDTH-1:0] people, bounds;

  // True when the group touches or passes either boundary bit.
  function automatic logic overlaps(input logic [7:0] p, input logic [7:0] bl,
                                    input logic [7:0] br);
    return ({1'b0, p} + 9'(HALF) >= {1'b0, bl}) || ({1'b0, p} <= {1'b0, br} + 9'(HALF));
  endfunction

  // Step period minus one for a speed level, never below a period of one.
  function automatic logic [TW-1:0] period_m1(input logic [SW-1:0] lvl);
    int unsigned sh;
    int unsigned p;
    sh = PERIOD_SHIFT * 32'(lvl);
    p  = (sh >= 32) ? 0 : (BASE_PERIOD >> sh);
    if (p == 0) p = 1;
    return TW'(p - 1);
  endfunction

  assign bl_live   = 8'(WIDTH - 1 - 32'(cliff_l));
  assign br_live   = 8'(cliff_r);
  // Live cliffs steer IDLE; a run uses the copy frozen at start.
  assign bl_act    = (state_q == StIdle) ? bl_live : bl_q;
  assign br_act    = (state_q == StIdle) ? br_live : br_q;
  assign ovl       = overlaps(pos_q, bl_act, br_act);
  assign can_left  = ({1'b0, pos_q} + 9'(HALF + 1)) < {1'b0, bl_live};
  assign can_right = {1'b0, pos_q} > ({1'b0, br_live} + 9'(HALF + 1));
  assign per_m1    = period_m1(speed_q);
  assign move      = (tick_q == per_m1) && (dir_q != DirNone);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; start_p wins over every other input.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_p && !ovl) state_d = StRun;
      StRun: begin
        if (start_p)  state_d = StIdle;
        else if (ovl) state_d = StLose;
      end
      StLose:  if (start_p) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Speed level: saturating up/down, frozen in LOSE, conflicting pulses cancel.
  always_comb begin
    speed_d = speed_q;
    if (state_q != StLose) begin
      if (speed_up_p && !speed_down_p && (speed_q != SW'(LEVELS - 1))) begin
        speed_d = speed_q + SW'(1);
      end else if (speed_down_p && !speed_up_p && (speed_q != '0)) begin
        speed_d = speed_q - SW'(1);
      end
    end
    speed_chg = (speed_d != speed_q);
  end

  // Datapath next-state: position, direction, score, timers and latched cliffs.
  always_comb begin
    pos_d       = pos_q;
    dir_d       = dir_q;
    score_d     = score_q;
    step_d      = 1'b0;
    tick_d      = tick_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    bl_d        = bl_q;
    br_d        = br_q;
    unique case (state_q)
      StIdle: begin
        tick_d      = '0;
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (start_p) begin
          if (!ovl) begin
            bl_d    = bl_live;
            br_d    = br_live;
            dir_d   = DirNone;
            score_d = '0;
          end
        end else if (left_p && !right_p && can_left) begin
          pos_d = pos_q + 8'd1;
        end else if (right_p && !left_p && can_right) begin
          pos_d = pos_q - 8'd1;
        end
      end
      StRun: begin
        if (start_p) begin
          pos_d  = 8'(START_IDX);
          dir_d  = DirNone;
          tick_d = '0;
        end else if (!ovl) begin
          if (move) begin
            pos_d  = (dir_q == DirLeft) ? pos_q + 8'd1 : pos_q - 8'd1;
            step_d = 1'b1;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end
          if (left_p && !right_p)      dir_d = DirLeft;
          else if (right_p && !left_p) dir_d = DirRight;
          if (speed_chg || (tick_q == per_m1)) tick_d = '0;
          else                                 tick_d = tick_q + TW'(1);
        end
      end
      StLose: begin
        if (start_p) begin
          pos_d       = 8'(START_IDX);
          score_d     = '0;
          dir_d       = DirNone;
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
          blink_cnt_d = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q       <= 8'(START_IDX);
      dir_q       <= DirNone;
      speed_q     <= '0;
      score_q     <= '0;
      step_q      <= 1'b0;
      tick_q      <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      bl_q        <= '0;
      br_q        <= '0;
    end else begin
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      speed_q     <= speed_d;
      score_q     <= score_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      bl_q        <= bl_d;
      br_q        <= br_d;
    end
  end

  // People image: GROUP adjacent bits centred on pos.
  always_comb begin
    people = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((i + HALF >= 32'(pos_q)) && (i <= 32'(pos_q) + HALF)) people[i] = 1'b1;
    end
  end

  // LED image per state: people plus cliffs, people only, or the lose blink.
  always_comb begin
    bounds = (WIDTH'(1) << bl_act) | (WIDTH'(1) << br_act);
    unique case (state_q)
      StIdle:  led = people | bounds;
      StRun:   led = people;
      StLose:  led = blink_off_q ? '0 : '1;
      default: led = people;
    endcase
  end

  assign state = state_q;
  assign speed = speed_q;
  assign pos   = pos_q;
  assign score = score_q;
  assign step  = step_q;

endmodule

// File: tb/tb_cliff_game_core.sv
// Bench for cliff_game_core: directed scenarios plus random pulses, checked
// each cycle against a rule-level model of the game.
module tb_cliff_game_core;
  localparam int W = 16, G = 3, H = 1, ST = 7, LV = 3, BP = 16, PS = 2, BK = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        start_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
  logic        speed_up_p = 1'b0, speed_down_p = 1'b0;
  logic [2:0]  cliff_l = '0, cliff_r = '0;
  logic [15:0] led;
  logic [1:0]  state;
  logic [1:0]  speed;
  logic [7:0]  pos;
  logic [15:0] score;
  logic        step;
  logic [44:0] obs, exp_v;

  int checks = 0, failures = 0;
  // Model: state 0/1/2, dir +1 left / -1 right / 0 none,
  // m_run = RUN cycles since start or last speed change, m_lose = cycles in LOSE.
  int m_state, m_pos, m_speed, m_dir, m_score, m_step, m_run, m_lose, m_bl, m_br;

  cliff_game_core #(
    .WIDTH(W), .GROUP(G), .START_IDX(ST), .CW(3), .LEVELS(LV),
    .BASE_PERIOD(BP), .PERIOD_SHIFT(PS), .BLINK_PERIOD(BK)
  ) dut (
    .clk(clk), .reset(reset), .start_p(start_p), .left_p(left_p), .right_p(right_p),
    .speed_up_p(speed_up_p), .speed_down_p(speed_down_p),
    .cliff_l(cliff_l), .cliff_r(cliff_r),
    .led(led), .state(state), .speed(speed), .pos(pos), .score(score), .step(step)
  );

  always #5 clk = ~clk;

  assign obs = {led, state, speed, pos, score, step};

  function automatic int per_of(int lvl);
    int p;
    p = BP >> (PS * lvl);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic bit ovl(int p, int bl, int br);
    return (p + H >= bl) || (p - H <= br);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = ST; m_speed = 0; m_dir = 0; m_score = 0;
    m_step = 0; m_run = 0; m_lose = 0; m_bl = 0; m_br = 0;
  endtask

  task automatic model_update(input bit s, input bit l, input bit r, input bit u, input bit d);
    int bl_live, br_live, nspeed, per;
    bit chg;
    bl_live = W - 1 - int'(cliff_l);
    br_live = int'(cliff_r);
    nspeed  = m_speed;
    per     = per_of(m_speed);
    m_step  = 0;
    if (m_state != 2 && (u ^ d)) begin
      if (u && m_speed < LV - 1) nspeed = m_speed + 1;
      if (d && m_speed > 0)      nspeed = m_speed - 1;
    end
    chg = (nspeed != m_speed);
    case (m_state)
      0: begin
        if (s) begin
          if (!ovl(m_pos, bl_live, br_live)) begin
            m_state = 1; m_bl = bl_live; m_br = br_live;
            m_dir = 0; m_score = 0; m_run = 0;
          end
        end else if (l && !r && m_pos + H + 1 < bl_live) m_pos++;
        else if (r && !l && m_pos - H - 1 > br_live) m_pos--;
      end
      1: begin
        if (s) begin
          m_state = 0; m_pos = ST; m_dir = 0;
        end else if (ovl(m_pos, m_bl, m_br)) begin
          m_state = 2; m_lose = 0;
        end else begin
          if ((m_run % per) == per - 1 && m_dir != 0) begin
            m_pos += m_dir;
            if (m_score < 65535) m_score++;
            m_step = 1;
          end
          if (l && !r)      m_dir = 1;
          else if (r && !l) m_dir = -1;
          m_run = chg ? 0 : m_run + 1;
        end
      end
      default: begin
        if (s) begin
          m_state = 0; m_pos = ST; m_score = 0; m_dir = 0;
        end else m_lose++;
      end
    endcase
    m_speed = nspeed;
  endtask

  function automatic logic [44:0] exp_vec();
    logic [15:0] l;
    l = '0;
    if (m_state == 2) begin
      l = ((m_lose / BK) % 2 == 0) ? 16'hFFFF : 16'h0000;
    end else begin
      for (int i = 0; i < W; i++) if (i >= m_pos - H && i <= m_pos + H) l[i] = 1'b1;
      if (m_state == 0) begin
        l[W - 1 - int'(cliff_l)] = 1'b1;
        l[int'(cliff_r)] = 1'b1;
      end
    end
    return {l, 2'(m_state), 2'(m_speed), 8'(m_pos), 16'(m_score), 1'(m_step)};
  endfunction

  // One clock of stimulus, entered and left on the falling edge.
  task automatic drive(input bit s, input bit l, input bit r, input bit u, input bit d);
    start_p = s; left_p = l; right_p = r; speed_up_p = u; speed_down_p = d;
    @(posedge clk);
    model_update(s, l, r, u, d);
    @(negedge clk);
    start_p = 0; left_p = 0; right_p = 0; speed_up_p = 0; speed_down_p = 0;
  endtask

  task automatic apply_reset(input logic [2:0] cl, input logic [2:0] cr);
    cliff_l = cl; cliff_r = cr;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(3'd0, 3'd0);
    exp_v = exp_vec();
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v);
    end
    checks++;
    if (led !== 16'h81C1 || state !== 2'd0 || pos !== 8'd7 || speed !== 2'd0) begin
      failures++;
      $display("FAIL reset_values got led=%h st=%0d pos=%0d spd=%0d exp 81c1/0/7/0",
               led, state, pos, speed);
    end
  endtask

  task automatic test_idle_move();
    apply_reset(3'd2, 3'd0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0, 0);
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL idle_move[%0d] got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (pos !== 8'd11 || led !== 16'h3C01) begin
      failures++; $display("FAIL idle_clamp got pos=%0d led=%h exp 11/3c01", pos, led);
    end
    drive(0, 1, 1, 0, 0);
    checks++;
    if (pos !== 8'd11) begin
      failures++; $display("FAIL idle_both got=%0d exp=11", pos);
    end
  endtask

  task automatic test_run_left_lose();
    int last, nstep, lose_seen;
    last = -1; nstep = 0; lose_seen = 0;
    apply_reset(3'd0, 3'd0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 400 && lose_seen == 0; c++) begin
      drive(0, 0, 0, 0, 0);
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL run_left[%0d] got=%h exp=%h", c, obs, exp_v);
      end
      if (step === 1'b1) begin
        nstep++;
        if (last < 0) begin
          checks++;
          if (led !== 16'h0380) begin
            failures++; $display("FAIL first_step_led got=%h exp=0380", led);
          end
        end else begin
          checks++;
          if (c - last != 16) begin
            failures++; $display("FAIL step_gap got=%0d exp=16", c - last);
          end
        end
        last = c;
        if (pos === 8'd14) begin
          drive(0, 0, 0, 0, 0);
          checks++;
          if (state !== 2'd2 || score !== 16'd7 || led !== 16'hFFFF) begin
            failures++;
            $display("FAIL lose_entry got st=%0d score=%0d led=%h exp 2/7/ffff",
                     state, score, led);
          end
          lose_seen = 1;
        end
      end
    end
    checks++;
    if (lose_seen == 0) begin
      failures++; $display("FAIL run_left_timeout got steps=%0d exp=7", nstep);
    end
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 1, 0);
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL blink[%0d] got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 3) begin
        checks++;
        if (led !== 16'h0000) begin
          failures++; $display("FAIL blink_off got=%h exp=0000", led);
        end
      end
    end
  endtask

  task automatic test_fast_right();
    int nstep, lose_seen;
    nstep = 0; lose_seen = 0;
    apply_reset(3'd0, 3'd0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      if (step === 1'b1) nstep++;
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL speed_up[%0d] got=%h exp=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (speed !== 2'd2) begin
      failures++; $display("FAIL speed_sat got=%0d exp=2", speed);
    end
    for (int c = 0; c < 50 && lose_seen == 0; c++) begin
      drive(0, 0, 0, 0, 0);
      if (step === 1'b1) nstep++;
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL fast[%0d] got=%h exp=%h", c, obs, exp_v);
      end
      if (state === 2'd2) lose_seen = 1;
    end
    checks++;
    if (lose_seen == 0 || score !== 16'd6 || pos !== 8'd1 || nstep != 6) begin
      failures++;
      $display("FAIL fast_lose got lose=%0d score=%0d pos=%0d steps=%0d exp 1/6/1/6",
               lose_seen, score, pos, nstep);
    end
  endtask

  task automatic test_start_refused();
    apply_reset(3'd0, 3'd6);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL start_refused got=%0d exp=0", state);
    end
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    exp_v = exp_vec();
    checks++;
    if (state !== 2'd1 || obs !== exp_v) begin
      failures++; $display("FAIL start_after_move got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_abort_and_reset();
    int hit;
    hit = 0;
    apply_reset(3'd2, 3'd3);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 200 && hit == 0; c++) begin
      drive(0, 0, 0, 0, 0);
      if (pos === 8'd10) hit = 1;
    end
    checks++;
    if (hit == 0) begin
      failures++; $display("FAIL abort_timeout got pos=%0d exp=10", pos);
    end
    drive(1, 0, 0, 0, 0);
    exp_v = exp_vec();
    checks++;
    if (state !== 2'd0 || pos !== 8'd7 || score !== 16'd3 || obs !== exp_v) begin
      failures++; $display("FAIL abort got=%h exp=%h", obs, exp_v);
    end
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);
    cliff_l = 3'd0; cliff_r = 3'd0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {16'h81C1, 2'd0, 2'd0, 8'd7, 16'd0, 1'b0}) begin
      failures++; $display("FAIL async_reset got=%h exp=81c1/0/0/7/0/0", obs);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit s, l, r, u, d;
    apply_reset(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 0 && $urandom_range(0, 19) == 0) begin
        cliff_l = 3'($urandom_range(0, 7));
        cliff_r = 3'($urandom_range(0, 7));
      end
      s = ($urandom_range(0, 99) < 3);
      l = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 99) < 10);
      u = ($urandom_range(0, 99) < 5);
      d = ($urandom_range(0, 99) < 5);
      drive(s, l, r, u, d);
      exp_v = exp_vec();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL random[%0d] got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_move();
    test_run_left_lose();
    test_fast_right();
    test_start_refused();
    test_abort_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
